lut_neuron_array: RTL and testbench

- Parametrised successor to the single fixed-table LogicNets neuron ROM.
- Holds NUM_NEURONS truth tables, each IN_BITS -> OUT_BITS, in registers that are loaded at runtime through a config port.
- Evaluates all neurons in parallel behind a registered valid/ready output stage.
- Sits between layer stages so one netlist can be retargeted to new trained weights without resynthesis.

---
 rtl/lut_neuron_array.sv | 108 ++++++++++
 tb/tb_lut_neuron_array.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_array.sv
// rtl/lut_neuron_array.sv - runtime-loadable array of LUT neurons with a registered valid/ready output stage
module lut_neuron_array #(
    parameter int IN_BITS     = 6,
    parameter int OUT_BITS    = 1,
    parameter int NUM_NEURONS = 4,
    parameter int NIDX_W      = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_start,
    input  logic                            cfg_we,
    input  logic [NIDX_W-1:0]               cfg_neuron,
    input  logic [IN_BITS-1:0]              cfg_entry,
    input  logic [OUT_BITS-1:0]             cfg_data,
    input  logic                            cfg_done,
    output logic                            cfg_busy,
    output logic                            cfg_err,
    output logic                            loaded
);

    localparam int DEPTH = 1 << IN_BITS;

    typedef enum logic [1:0] {
        S_UNCFG,
        S_DRAIN,
        S_LOAD,
        S_RUN
    } state_t;

    state_t              state;
    logic [OUT_BITS-1:0] tbl [NUM_NEURONS][DEPTH];

    logic accept;
    logic start_ok;
    logic neuron_ok;
    logic write_en;
    logic err_set;

    assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign cfg_busy  = (state == S_DRAIN) || (state == S_LOAD);
    assign start_ok  = cfg_start && ((state == S_UNCFG) || (state == S_RUN));
    assign neuron_ok = 32'(cfg_neuron) < NUM_NEURONS;
    assign write_en  = (state == S_LOAD) && cfg_we && neuron_ok;
    assign err_set   = cfg_we && ((state != S_LOAD) || !neuron_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_UNCFG;
            cfg_err <= 1'b0;
            loaded  <= 1'b0;
        end else begin
            case (state)
                S_UNCFG, S_RUN: begin
                    if (cfg_start) state <= S_DRAIN;
                end
                // Leave DRAIN only after the output register has been seen empty for a cycle.
                S_DRAIN: begin
                    if (!out_valid) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (cfg_done) begin
                        state  <= S_RUN;
                        loaded <= 1'b1;
                    end
                end
                default: state <= S_UNCFG;
            endcase

            if (err_set)
                cfg_err <= 1'b1;
            else if (start_ok)
                cfg_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NEURONS; n++)
                for (int e = 0; e < DEPTH; e++)
                    tbl[n][e] <= '0;
        end else if (write_en) begin
            for (int n = 0; n < NUM_NEURONS; n++)
                if (cfg_neuron == NIDX_W'(n))
                    tbl[n][cfg_entry] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            for (int n = 0; n < NUM_NEURONS; n++)
                out_data[n*OUT_BITS +: OUT_BITS] <= tbl[n][in_data[n*IN_BITS +: IN_BITS]];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lut_neuron_array.sv
// tb/tb_lut_neuron_array.sv - directed self-checking bench for lut_neuron_array
module tb_lut_neuron_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        cfg_start;
    logic        cfg_we;
    logic [2:0]  cfg_neuron;
    logic [5:0]  cfg_entry;
    logic [0:0]  cfg_data;
    logic        cfg_done;
    logic        cfg_busy;
    logic        cfg_err;
    logic        loaded;

    int errors = 0;
    int checks = 0;
    logic exp_tab [4][64];

    lut_neuron_array #(
        .IN_BITS(6), .OUT_BITS(1), .NUM_NEURONS(4), .NIDX_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_start(cfg_start), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
        .cfg_entry(cfg_entry), .cfg_data(cfg_data), .cfg_done(cfg_done),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err), .loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model(input logic [23:0] d);
        logic [3:0] r;
        for (int n = 0; n < 4; n++) r[n] = exp_tab[n][d[n*6 +: 6]];
        return r;
    endfunction

    function automatic logic [23:0] mk(input int i);
        logic [5:0] a0, a1, a2, a3;
        a0 = 6'(i);
        a1 = 6'(i + 17);
        a2 = 6'(i + 34);
        a3 = 6'(i + 51);
        return {a3, a2, a1, a0};
    endfunction

    task automatic wr(input int n, input int e, input logic d);
        cfg_we = 1'b1; cfg_neuron = 3'(n); cfg_entry = 6'(e); cfg_data = d;
        tick();
        cfg_we = 1'b0;
        if (n < 4) exp_tab[n][e] = d;
    endtask

    task automatic enter_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("drain_busy", cfg_busy, 1);
        chk("drain_ready", in_ready, 0);
        tick();
        chk("load_busy", cfg_busy, 1);
    endtask

    task automatic finish_load();
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        chk("done_loaded", loaded, 1);
        chk("done_busy", cfg_busy, 0);
    endtask

    task automatic lookup(input logic [23:0] d);
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        #1;
        chk("lookup_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("lookup_valid", out_valid, 1);
        chk("lookup_data", out_data, model(d));
    endtask

    initial begin
        int sent, recv;
        logic [3:0] expq[$];
        logic [3:0] held;
        logic [3:0] held_exp;
        bit stall, acc, take;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cfg_start = 1'b0; cfg_we = 1'b0; cfg_neuron = '0; cfg_entry = '0;
        cfg_data = '0; cfg_done = 1'b0;
        for (int n = 0; n < 4; n++)
            for (int e = 0; e < 64; e++) exp_tab[n][e] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_loaded", loaded, 0);

        in_valid = 1'b1; in_data = 24'h123456; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("uncfg_idle", {in_ready, out_valid, loaded}, 0);
        end
        in_valid = 1'b0;

        enter_load();
        wr(0, 6'h05, 1); wr(0, 6'h07, 1); wr(0, 6'h15, 1); wr(0, 6'h17, 1);
        wr(0, 6'h25, 1); wr(0, 6'h27, 1); wr(0, 6'h35, 1); wr(0, 6'h37, 1);
        chk("load_no_err", cfg_err, 0);
        finish_load();

        out_ready = 1'b1; in_valid = 1'b1; in_data = 24'h000005;
        #1;
        chk("s1_ready", in_ready, 1);
        chk("s1_latency", out_valid, 0);
        tick();
        chk("s1_valid", out_valid, 1);
        chk("s1_data", out_data, 4'b0001);
        in_data = 24'h00000D;
        tick();
        chk("s2_data", out_data, 4'b0000);
        in_data = 24'h000037;
        tick();
        chk("s3_data", out_data, 4'b0001);
        in_valid = 1'b0;
        tick();
        chk("s_drop", out_valid, 0);

        enter_load();
        for (int n = 0; n < 4; n++)
            for (int e = 0; e < 64; e++) wr(n, e, 1'($urandom_range(0, 1)));
        finish_load();

        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 2000 && recv < 64; cyc++) begin
            in_valid = (sent < 64); in_data = mk(sent);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid && in_ready;
            take = out_valid && out_ready;
            stall = out_valid && !out_ready;
            held = out_data;
            if (take) begin
                chk("sweep_data", out_data, (expq.size() > 0) ? expq.pop_front() : 4'hx);
                recv++;
            end
            if (acc) begin
                expq.push_back(model(in_data));
                sent++;
            end
            tick();
            if (stall) chk("sweep_stall", {out_valid, out_data}, {1'b1, held});
        end
        in_valid = 1'b0;
        chk("sweep_count", recv, 64);
        chk("sweep_left", expq.size(), 0);

        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = mk(i * 3 + 5);
            #1;
            chk("tput_ready", in_ready, 1);
            tick();
            chk("tput_data", {out_valid, out_data}, {1'b1, model(in_data)});
        end
        in_valid = 1'b0;
        tick();

        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(9);
        held_exp = model(in_data);
        tick();
        in_valid = 1'b0;
        chk("hold_valid", out_valid, 1);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_busy", cfg_busy, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_word", {out_valid, out_data}, {1'b1, held_exp});
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("hold_taken", out_data, held_exp);
        tick();
        chk("hold_empty", out_valid, 0);
        chk("hold_still_drain", cfg_busy, 1);
        tick();
        wr(2, 6'h10, ~exp_tab[2][16]);
        chk("hold_load_write", cfg_err, 0);
        finish_load();
        lookup({6'h00, 6'h10, 6'h00, 6'h00});

        cfg_we = 1'b1; cfg_neuron = 3'd0; cfg_entry = 6'h05; cfg_data = ~exp_tab[0][5];
        tick();
        cfg_we = 1'b0;
        chk("err_run_we", cfg_err, 1);
        lookup({6'h00, 6'h10, 6'h00, 6'h05});
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("err_clear", cfg_err, 0);
        tick();
        cfg_we = 1'b1; cfg_neuron = 3'd4; cfg_entry = 6'h00; cfg_data = ~exp_tab[0][0];
        tick();
        cfg_we = 1'b0;
        chk("err_bad_neuron", cfg_err, 1);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("err_start_in_load", {cfg_err, cfg_busy}, 2'b11);
        cfg_we = 1'b1; cfg_neuron = 3'd1; cfg_entry = 6'h3F; cfg_data = ~exp_tab[1][63];
        cfg_done = 1'b1;
        tick();
        exp_tab[1][63] = cfg_data[0];
        cfg_we = 1'b0; cfg_done = 1'b0;
        chk("we_done_busy", cfg_busy, 0);
        lookup({6'h00, 6'h00, 6'h3F, 6'h00});
        lookup(24'h000000);
        cfg_start = 1'b1; cfg_we = 1'b1; cfg_neuron = 3'd0;
        tick();
        cfg_start = 1'b0; cfg_we = 1'b0;
        chk("err_set_wins", {cfg_err, cfg_busy}, 2'b11);
        tick();
        finish_load();

        enter_load();
        for (int e = 0; e < 10; e++) wr(3, e, 1);
        wr(5, 0, 1);
        chk("pre_rst_err", cfg_err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", cfg_busy, 0);
        chk("mid_rst_err", cfg_err, 0);
        chk("mid_rst_loaded", loaded, 0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++)
            for (int e = 0; e < 64; e++) exp_tab[n][e] = 1'b0;
        enter_load();
        finish_load();
        for (int i = 0; i < 64; i++) begin
            lookup({4{6'(i)}});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
